fft_agu_param: RTL and testbench



---
 rtl/fft_agu_param.sv | 140 ++++++++++++++
 tb/tb_fft_agu_param.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_param.sv
`default_nettype none
// ============================================================================
// Module  : fft_agu_param
// Brief   : Radix-2 in-place FFT address generator (DIF/DIT), one butterfly
//           descriptor per valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module fft_agu_param #(
  parameter int LOG2N = 5,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_dit,
  input  logic             inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             tw_conj,
  output logic [SW-1:0]    stage,
  output logic             last_in_stage,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int            BW           = LOG2N - 1;
  localparam logic [SW-1:0] c_last_stage = SW'(LOG2N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_stage, w_stage_nxt;
  logic [BW-1:0] r_bfly,  w_bfly_nxt;
  logic [BW-1:0] r_grp,   w_grp_nxt;
  logic          r_dit,   w_dit_nxt;
  logic          r_inv,   w_inv_nxt;

  logic [SW-1:0]    w_sh;
  logic [SW-1:0]    w_gsh;
  logic [LOG2N-1:0] w_stride;
  logic [LOG2N-1:0] w_gspan;
  logic [BW-1:0]    w_bmask;
  logic [BW-1:0]    w_gmask;
  logic [LOG2N-1:0] w_addr_a;
  logic [BW-1:0]    w_tw;
  logic             w_lis;
  logic             w_last;
  logic             w_fire;

  // Stride is 1<<w_sh and the group count is 1<<w_gsh; w_sh + w_gsh = LOG2N-1.
  assign w_sh     = r_dit ? r_stage : (c_last_stage - r_stage);
  assign w_gsh    = c_last_stage - w_sh;
  assign w_stride = LOG2N'(1) << w_sh;
  assign w_gspan  = LOG2N'(1) << w_gsh;
  assign w_bmask  = w_stride[BW-1:0] - BW'(1);
  assign w_gmask  = w_gspan[BW-1:0] - BW'(1);

  // g*2S + b: bit w_sh of addr_a is always clear, so addr_b is a simple OR.
  assign w_addr_a = (({1'b0, r_grp} << w_sh) << 1) | {1'b0, r_bfly};
  // DIF shifts by s, DIT by LOG2N-1-s; both equal w_gsh.
  assign w_tw     = r_bfly << w_gsh;
  assign w_lis    = (r_bfly == w_bmask) && (r_grp == w_gmask);
  assign w_last   = w_lis && (r_stage == c_last_stage);
  assign w_fire   = (r_state == ST_RUN) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_bfly_nxt  = r_bfly;
    w_grp_nxt   = r_grp;
    w_dit_nxt   = r_dit;
    w_inv_nxt   = r_inv;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_bfly_nxt  = '0;
          w_grp_nxt   = '0;
          w_dit_nxt   = mode_dit;
          w_inv_nxt   = inverse;
        end
      end
      ST_RUN: begin
        if (w_fire) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else if (r_bfly == w_bmask) begin
            w_bfly_nxt = '0;
            if (r_grp == w_gmask) begin
              w_grp_nxt   = '0;
              w_stage_nxt = r_stage + SW'(1);
            end else begin
              w_grp_nxt = r_grp + BW'(1);
            end
          end else begin
            w_bfly_nxt = r_bfly + BW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_bfly  <= '0;
      r_grp   <= '0;
      r_dit   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_bfly  <= w_bfly_nxt;
      r_grp   <= w_grp_nxt;
      r_dit   <= w_dit_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  // Descriptor fields read as zero whenever nothing is being offered.
  assign out_valid     = (r_state == ST_RUN);
  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign addr_a        = out_valid ? w_addr_a : '0;
  assign addr_b        = out_valid ? (w_addr_a | w_stride) : '0;
  assign tw_idx        = out_valid ? w_tw : '0;
  assign tw_conj       = out_valid && r_inv;
  assign stage         = out_valid ? r_stage : '0;
  assign last_in_stage = out_valid && w_lis;
  assign last          = out_valid && w_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_agu_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_agu_param
// Brief   : Self-checking bench for fft_agu_param (N=32, N=4, N=1024 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_agu_param;

  typedef logic [63:0] desc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  // N = 32 instance
  logic       start5, mode5, inv5, ready5, valid5, conj5, lis5, last5, busy5, done5;
  logic [4:0] a5, b5;
  logic [3:0] tw5;
  logic [2:0] st5;

  // N = 4 instance
  logic       start2, mode2, inv2, ready2, valid2, conj2, lis2, last2, busy2, done2;
  logic [1:0] a2, b2;
  logic [0:0] tw2;
  logic [0:0] st2;

  // N = 1024 instance
  logic       start10, mode10, inv10, ready10, valid10, conj10, lis10, last10, busy10, done10;
  logic [9:0] a10, b10;
  logic [8:0] tw10;
  logic [3:0] st10;

  fft_agu_param #(.LOG2N(5)) u5 (
    .clk(clk), .reset(reset), .start(start5), .mode_dit(mode5), .inverse(inv5),
    .out_valid(valid5), .out_ready(ready5), .addr_a(a5), .addr_b(b5), .tw_idx(tw5),
    .tw_conj(conj5), .stage(st5), .last_in_stage(lis5), .last(last5), .busy(busy5), .done(done5));

  fft_agu_param #(.LOG2N(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .mode_dit(mode2), .inverse(inv2),
    .out_valid(valid2), .out_ready(ready2), .addr_a(a2), .addr_b(b2), .tw_idx(tw2),
    .tw_conj(conj2), .stage(st2), .last_in_stage(lis2), .last(last2), .busy(busy2), .done(done2));

  fft_agu_param #(.LOG2N(10)) u10 (
    .clk(clk), .reset(reset), .start(start10), .mode_dit(mode10), .inverse(inv10),
    .out_valid(valid10), .out_ready(ready10), .addr_a(a10), .addr_b(b10), .tw_idx(tw10),
    .tw_conj(conj10), .stage(st10), .last_in_stage(lis10), .last(last10), .busy(busy10), .done(done10));

  desc_t exp_q[$];
  desc_t obs_q[$];

  function automatic desc_t pack(int a, int b, int tw, int st, int lis, int lst, int conj);
    return {5'd0, conj[0], lst[0], lis[0], st[7:0], tw[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference: textbook nested loops over stage, group, butterfly.
  function automatic void build_model(int log2n, bit dit, bit inv);
    int n;
    exp_q.delete();
    n = 1 << log2n;
    for (int s = 0; s < log2n; s++) begin
      int stride;
      int groups;
      stride = dit ? (1 << s) : (n >> (s + 1));
      groups = n / (2 * stride);
      for (int g = 0; g < groups; g++) begin
        for (int b = 0; b < stride; b++) begin
          int tw;
          int lis;
          tw  = dit ? (b << (log2n - 1 - s)) : (b << s);
          lis = (g == groups - 1) && (b == stride - 1);
          exp_q.push_back(pack(g * 2 * stride + b, g * 2 * stride + b + stride, tw, s,
                               lis, (lis != 0) && (s == log2n - 1), inv));
        end
      end
    end
  endfunction

  task automatic start5_run(input bit dit, input bit inv);
    @(negedge clk);
    start5 = 1'b1; mode5 = dit; inv5 = inv;
    @(negedge clk);
    start5 = 1'b0; mode5 = ~dit; inv5 = ~inv;
  endtask

  // Gathers handshaken descriptors of the N=32 instance until done is seen.
  task automatic collect5(input bit rand_ready, input bit jitter, input int start_hs,
                          input bit start_last, output int hs, output int unstable,
                          output int gaps, output int done_gap);
    desc_t cur;
    desc_t held;
    bit    holding;
    bit    fin;
    int    since_last;
    holding = 0; fin = 0; since_last = -1;
    held = '0;
    obs_q.delete();
    hs = 0; unstable = 0; gaps = 0; done_gap = -1;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      cur = pack(a5, b5, tw5, st5, lis5, last5, conj5);
      start5 = 1'b0;
      if (since_last >= 0) begin
        since_last++;
        if (done5) begin
          done_gap = since_last;
          fin = 1;
        end
      end else if (valid5) begin
        if (holding && cur !== held) unstable++;
        ready5 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (jitter) begin
          mode5 = 1'($urandom_range(0, 1));
          inv5  = 1'($urandom_range(0, 1));
        end
        if (start_hs == hs) start5 = 1'b1;
        if (ready5) begin
          obs_q.push_back(cur);
          hs++;
          holding = 0;
          if (last5) begin
            since_last = 0;
            if (start_last) start5 = 1'b1;
          end
        end else begin
          holding = 1;
          held = cur;
        end
      end else begin
        gaps++;
      end
      if (!fin) @(negedge clk);
    end
    ready5 = 1'b1;
    start5 = 1'b0;
  endtask

  task automatic test_reset;
    desc_t cur;
    int hs, unst, gaps, dg;
    vectors++;
    if ({valid5, busy5, done5, a5, b5, tw5, conj5, st5, lis5, last5,
         valid2, busy2, done2, valid10, busy10, done10} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid/busy/done %b%b%b a=%0d b=%0d, required all zero",
               valid5, busy5, done5, a5, b5);
    end
    start5_run(1'b0, 1'b0);
    ready5 = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({valid5, busy5, done5, a5, b5, tw5, conj5, st5, lis5, last5} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: got valid=%b busy=%b done=%b a=%0d b=%0d tw=%0d st=%0d, required all zero",
               valid5, busy5, done5, a5, b5, tw5, st5);
    end
    start5_run(1'b0, 1'b0);
    cur = pack(a5, b5, tw5, st5, lis5, last5, conj5);
    vectors++;
    if (!valid5 || cur !== pack(0, 16, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL restart_first: got valid=%b desc=%h, required valid=1 desc=%h",
               valid5, cur, pack(0, 16, 0, 0, 0, 0, 0));
    end
    collect5(1'b0, 1'b0, -1, 1'b0, hs, unst, gaps, dg);
    vectors++;
    if (hs !== 80) begin
      errors++;
      $display("FAIL restart_count: got %0d handshakes, required 80", hs);
    end
  endtask

  task automatic test_dif_stream;
    int hs, unst, gaps, dg;
    desc_t got;
    desc_t pts[5];
    int    idx[5];
    start5_run(1'b0, 1'b0);
    collect5(1'b0, 1'b0, -1, 1'b0, hs, unst, gaps, dg);
    build_model(5, 1'b0, 1'b0);
    vectors++;
    if (hs !== 80 || gaps !== 0 || dg !== 1) begin
      errors++;
      $display("FAIL dif_timing: got hs=%0d gaps=%0d done_gap=%0d, required 80/0/1", hs, gaps, dg);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL dif_desc[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    pts[0] = pack(0, 16, 0, 0, 0, 0, 0);  idx[0] = 0;
    pts[1] = pack(1, 17, 1, 0, 0, 0, 0);  idx[1] = 1;
    pts[2] = pack(2, 18, 2, 0, 0, 0, 0);  idx[2] = 2;
    pts[3] = pack(3, 11, 6, 1, 0, 0, 0);  idx[3] = 19;
    pts[4] = pack(30, 31, 0, 4, 1, 1, 0); idx[4] = 79;
    for (int k = 0; k < 5; k++) begin
      got = (idx[k] < obs_q.size()) ? obs_q[idx[k]] : '1;
      vectors++;
      if (got !== pts[k]) begin
        errors++;
        $display("FAIL dif_point[%0d]: got %h, required %h", idx[k], got, pts[k]);
      end
    end
  endtask

  task automatic test_dit_inverse;
    int hs, unst, gaps, dg, lis_cnt;
    desc_t got;
    start5_run(1'b1, 1'b1);
    collect5(1'b0, 1'b1, -1, 1'b0, hs, unst, gaps, dg);
    build_model(5, 1'b1, 1'b1);
    lis_cnt = 0;
    foreach (obs_q[i]) if (obs_q[i][56]) lis_cnt++;
    vectors++;
    if (hs !== 80 || lis_cnt !== 5) begin
      errors++;
      $display("FAIL dit_counts: got hs=%0d last_in_stage=%0d, required 80/5", hs, lis_cnt);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL dit_desc[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int hs, unst, gaps, dg;
    desc_t got;
    start5_run(1'b0, 1'b0);
    collect5(1'b1, 1'b0, -1, 1'b0, hs, unst, gaps, dg);
    build_model(5, 1'b0, 1'b0);
    vectors++;
    if (hs !== 80 || unst !== 0 || dg !== 1) begin
      errors++;
      $display("FAIL bp_summary: got hs=%0d unstable=%0d done_gap=%0d, required 80/0/1", hs, unst, dg);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_desc[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int hs, unst, gaps, dg;
    start5_run(1'b0, 1'b0);
    collect5(1'b0, 1'b0, 7, 1'b1, hs, unst, gaps, dg);
    vectors++;
    if (hs !== 80 || dg !== 1) begin
      errors++;
      $display("FAIL start_in_run: got hs=%0d done_gap=%0d, required 80/1", hs, dg);
    end
    @(negedge clk);
    vectors++;
    if (done5 !== 1'b1 || valid5 !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got done=%b valid=%b, required 1/0", done5, valid5);
    end
    start5 = 1'b1; mode5 = 1'b0; inv5 = 1'b0;
    @(negedge clk);
    start5 = 1'b0;
    vectors++;
    if (done5 !== 1'b0 || valid5 !== 1'b1 || busy5 !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b valid=%b busy=%b, required 0/1/1", done5, valid5, busy5);
    end
    collect5(1'b0, 1'b0, -1, 1'b0, hs, unst, gaps, dg);
    vectors++;
    if (hs !== 80 || dg !== 1) begin
      errors++;
      $display("FAIL second_run: got hs=%0d done_gap=%0d, required 80/1", hs, dg);
    end
  endtask

  task automatic test_n4;
    desc_t want[4];
    desc_t got;
    want[0] = pack(0, 2, 0, 0, 0, 0, 0);
    want[1] = pack(1, 3, 1, 0, 1, 0, 0);
    want[2] = pack(0, 1, 0, 1, 0, 0, 0);
    want[3] = pack(2, 3, 0, 1, 1, 1, 0);
    @(negedge clk);
    start2 = 1'b1; mode2 = 1'b0; inv2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = valid2 ? pack(a2, b2, tw2, st2, lis2, last2, conj2) : '1;
      vectors++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL n4_desc[%0d]: got %h, required %h", i, got, want[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (done2 !== 1'b1 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL n4_done: got done=%b valid=%b, required 1/0", done2, valid2);
    end
  endtask

  task automatic test_n1024;
    int    hs;
    desc_t got;
    build_model(10, 1'b0, 1'b0);
    @(negedge clk);
    start10 = 1'b1; mode10 = 1'b0; inv10 = 1'b0;
    @(negedge clk);
    start10 = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 20000 && hs < 5120; cyc++) begin
      if (valid10) begin
        ready10 = 1'($urandom_range(0, 1));
        if (ready10) begin
          got = pack(a10, b10, tw10, st10, lis10, last10, conj10);
          vectors++;
          if (got !== exp_q[hs]) begin
            errors++;
            $display("FAIL n1024_desc[%0d]: got %h, required %h", hs, got, exp_q[hs]);
          end
          hs++;
        end
      end
      @(negedge clk);
    end
    ready10 = 1'b1;
    vectors++;
    if (hs !== 5120 || done10 !== 1'b1) begin
      errors++;
      $display("FAIL n1024_end: got hs=%0d done=%b, required 5120/1", hs, done10);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start5 = 0;  mode5 = 0;  inv5 = 0;  ready5 = 1;
    start2 = 0;  mode2 = 0;  inv2 = 0;  ready2 = 1;
    start10 = 0; mode10 = 0; inv10 = 0; ready10 = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_dif_stream;
    test_dit_inverse;
    test_backpressure;
    test_start_ignored;
    test_n4;
    test_n1024;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
